// File: rtl/board_vga_renderer_pkg.sv
// rtl/board_vga_renderer_pkg.sv - shared board geometry, VGA timing, cell codes and colours
// Purpose: constants and helpers shared by the timing generator and the renderer.
// Ports: none (package).
package board_vga_renderer_pkg;

  // Board geometry
  localparam int BOARD_WIDTH  = 40;
  localparam int BOARD_HEIGHT = 30;
  localparam int BOARD_BITS   = BOARD_WIDTH * BOARD_HEIGHT * 3;
  localparam int CELL_PX      = 16;
  localparam int CELL_SHIFT   = $clog2(CELL_PX);

  localparam logic [5:0] CELL_H_LAST = 6'(BOARD_WIDTH - 1);
  localparam logic [4:0] CELL_V_LAST = 5'(BOARD_HEIGHT - 1);

  // Horizontal timing, in pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_LAST       = H_SYNC_END + H_BACK - 10'd1;

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_LAST       = V_SYNC_END + V_BACK - 10'd1;

  // Cell codes on the board_state bus
  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_UP    = 3'd1;
  localparam logic [2:0] CELL_DOWN  = 3'd2;
  localparam logic [2:0] CELL_LEFT  = 3'd3;
  localparam logic [2:0] CELL_RIGHT = 3'd4;
  localparam logic [2:0] CELL_DOT   = 3'd7;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = 12'h000;
  localparam rgb_t RGB_GREEN  = 12'h0F0;
  localparam rgb_t RGB_RED    = 12'hF00;
  localparam rgb_t RGB_YELLOW = 12'hFF0;

  // Snake segments go red once the game is over; unused codes 5/6 render black.
  function automatic rgb_t cell_colour(input logic [2:0] code, input logic over);
    case (code)
      CELL_UP, CELL_DOWN, CELL_LEFT, CELL_RIGHT: return over ? RGB_RED : RGB_GREEN;
      CELL_DOT: return RGB_YELLOW;
      default:  return RGB_BLACK;
    endcase
  endfunction

  // Bit offset of cell (h,v) in the flattened board, column-major.
  function automatic logic [11:0] cell_bit_index(input logic [5:0] h, input logic [4:0] v);
    return (12'(h) * 12'(BOARD_HEIGHT) + 12'(v)) * 12'd3;
  endfunction

endpackage

// File: rtl/board_vga_renderer_timing.sv
// rtl/board_vga_renderer_timing.sv - VGA timing generator: pixel divider plus hc/vc raster counters
// Purpose: produces the pixel enable and the 800x525 raster position with raw syncs.
// Ports: i_clk, i_rst (async, active-high) in; o_pix_en, o_hc, o_vc, o_hs, o_vs (active-low),
//        o_visible out.
module board_vga_renderer_timing
  import board_vga_renderer_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_pix_en,
  output logic [9:0] o_hc,
  output logic [9:0] o_vc,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_visible
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic             w_pix_en;

  // Enable fires on the last divider phase, so the first one lands PIX_DIV clks after reset.
  assign w_pix_en = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pix_en) begin
      if (r_hc == H_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  assign o_pix_en  = w_pix_en;
  assign o_hc      = r_hc;
  assign o_vc      = r_vc;
  assign o_hs      = !((r_hc >= H_SYNC_START) && (r_hc < H_SYNC_END));
  assign o_vs      = !((r_vc >= V_SYNC_START) && (r_vc < V_SYNC_END));
  assign o_visible = (r_hc < H_VISIBLE) && (r_vc < V_VISIBLE);

endmodule

// File: rtl/board_vga_renderer.sv
// rtl/board_vga_renderer.sv - board renderer: per-frame snapshot, 2-stage pixel pipeline, colour map
// Purpose: colours each 16x16 cell of the game board onto a 640x480@60 raster.
// Ports: clk, hard_reset (async, active-high), board_state, is_start_screen, is_over in;
//        vga_r/g/b, vga_hs, vga_vs (active-low), vga_blank_n, frame_tick out.
module board_vga_renderer
  import board_vga_renderer_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic                  clk,
  input  logic                  hard_reset,
  input  logic [BOARD_BITS-1:0] board_state,
  input  logic                  is_start_screen,
  input  logic                  is_over,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_blank_n,
  output logic                  frame_tick
);

  logic       w_pix_en;
  logic [9:0] w_hc;
  logic [9:0] w_vc;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_visible;

  board_vga_renderer_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .i_clk     (clk),
    .i_rst     (hard_reset),
    .o_pix_en  (w_pix_en),
    .o_hc      (w_hc),
    .o_vc      (w_vc),
    .o_hs      (w_hs_raw),
    .o_vs      (w_vs_raw),
    .o_visible (w_visible)
  );

  // Snapshot at the first pixel of vertical blank so a mid-frame tick cannot tear the image.
  logic                  w_snap;
  logic [BOARD_BITS-1:0] r_shadow;

  assign w_snap     = w_pix_en && (w_hc == '0) && (w_vc == V_VISIBLE);
  assign frame_tick = w_snap;

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      r_shadow <= '0;
    end else if (w_snap) begin
      r_shadow <= board_state;
    end
  end

  // Stage 1: cell coordinates, visibility, syncs and overlay selects.
  logic [5:0] r_s1_h;
  logic [4:0] r_s1_v;
  logic       r_s1_vis;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_start;
  logic       r_s1_over;

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      r_s1_h     <= '0;
      r_s1_v     <= '0;
      r_s1_vis   <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_start <= 1'b0;
      r_s1_over  <= 1'b0;
    end else if (w_pix_en) begin
      // Blanked positions collapse to cell (0,0) so the shadow is never addressed out of range.
      r_s1_h     <= w_visible ? 6'(w_hc >> CELL_SHIFT) : '0;
      r_s1_v     <= w_visible ? 5'(w_vc >> CELL_SHIFT) : '0;
      r_s1_vis   <= w_visible;
      r_s1_hs    <= w_hs_raw;
      r_s1_vs    <= w_vs_raw;
      r_s1_start <= is_start_screen;
      r_s1_over  <= is_over;
    end
  end

  // Stage 2: shadow lookup and colour map.
  logic [2:0] w_code;
  logic       w_ring;
  rgb_t       w_colour;

  assign w_code = r_shadow[cell_bit_index(r_s1_h, r_s1_v) +: 3];
  assign w_ring = (r_s1_h == '0) || (r_s1_h == CELL_H_LAST) ||
                  (r_s1_v == '0) || (r_s1_v == CELL_V_LAST);

  always_comb begin
    w_colour = RGB_BLACK;
    if (r_s1_vis) begin
      if (r_s1_start) begin
        w_colour = w_ring ? RGB_GREEN : RGB_BLACK;
      end else begin
        w_colour = cell_colour(w_code, r_s1_over);
      end
    end
  end

  rgb_t r_rgb;
  logic r_hs;
  logic r_vs;
  logic r_blank_n;

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      r_rgb     <= RGB_BLACK;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_pix_en) begin
      r_rgb     <= w_colour;
      r_hs      <= r_s1_hs;
      r_vs      <= r_s1_vs;
      r_blank_n <= r_s1_vis;
    end
  end

  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;

endmodule

// File: tb/tb_board_vga_renderer.sv
// tb/tb_board_vga_renderer.sv - self-checking bench for board_vga_renderer
module tb_board_vga_renderer;

  localparam int PD       = 2;
  localparam int BW       = 40;
  localparam int BH       = 30;
  localparam int NBITS    = BW * BH * 3;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int SNAP_T   = 480 * H_TOTAL;

  typedef struct {
    int         hc;
    int         vc;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
    logic       blank_n;
  } pix_t;

  logic             clk = 1'b0;
  logic             hard_reset;
  logic [NBITS-1:0] board_state;
  logic             is_start_screen;
  logic             is_over;
  logic [3:0]       vga_r, vga_g, vga_b;
  logic             vga_hs, vga_vs, vga_blank_n, frame_tick;

  board_vga_renderer dut (
    .clk             (clk),
    .hard_reset      (hard_reset),
    .board_state     (board_state),
    .is_start_screen (is_start_screen),
    .is_over         (is_over),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .vga_hs          (vga_hs),
    .vga_vs          (vga_vs),
    .vga_blank_n     (vga_blank_n),
    .frame_tick      (frame_tick)
  );

  always #5 clk = ~clk;

  int               n_total = 0;
  int               n_pass  = 0;
  int               clk_cnt;
  int               m_t;
  logic [NBITS-1:0] m_shadow;
  pix_t             pipe[$];
  pix_t             exp_out;
  logic             exp_tick;

  logic [15:0] w_obs;
  assign w_obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_tick};

  function automatic pix_t rst_pix();
    pix_t p;
    p.hc = -1; p.vc = -1; p.rgb = 12'h000; p.hs = 1'b1; p.vs = 1'b1; p.blank_n = 1'b0;
    return p;
  endfunction

  // What the screen should show at raster position t, from the video rules alone.
  function automatic pix_t expect_pixel(input int t);
    pix_t p;
    int hc, vc, ch, cv;
    logic [2:0] code;
    hc = t % H_TOTAL;
    vc = t / H_TOTAL;
    p.hc = hc;
    p.vc = vc;
    p.hs = !(hc >= 656 && hc < 752);
    p.vs = !(vc >= 490 && vc < 492);
    p.blank_n = (hc < 640) && (vc < 480);
    p.rgb = 12'h000;
    if (p.blank_n) begin
      ch = hc / 16;
      cv = vc / 16;
      if (is_start_screen) begin
        p.rgb = (ch == 0 || ch == BW - 1 || cv == 0 || cv == BH - 1) ? 12'h0F0 : 12'h000;
      end else begin
        code = m_shadow[(ch * BH + cv) * 3 +: 3];
        if (code >= 3'd1 && code <= 3'd4) p.rgb = is_over ? 12'hF00 : 12'h0F0;
        else if (code == 3'd7) p.rgb = 12'hFF0;
      end
    end
    return p;
  endfunction

  function automatic logic [15:0] exp_vec();
    return {exp_out.rgb, exp_out.hs, exp_out.vs, exp_out.blank_n, exp_tick};
  endfunction

  // Advance one clk (negedge to negedge); the model shows each pixel two pixel ticks late.
  task automatic step();
    pix_t pend;
    bit   pe;
    pe = ((clk_cnt + 1) % PD) == 0;
    if (pe) pend = expect_pixel(m_t);
    @(posedge clk);
    clk_cnt++;
    if (pe) begin
      exp_out = pipe.pop_front();
      pipe.push_back(pend);
      if (m_t == SNAP_T) m_shadow = board_state;
      m_t = (m_t + 1) % FRAME;
    end
    @(negedge clk);
    exp_tick = ((((clk_cnt + 1) % PD) == 0) && (m_t == SNAP_T));
  endtask

  task automatic release_reset();
    hard_reset = 1'b0;
    clk_cnt    = 0;
    m_t        = 0;
    m_shadow   = '0;
    pipe.delete();
    pipe.push_back(rst_pix());
    exp_out    = rst_pix();
    exp_tick   = 1'b0;
  endtask

  // Move the raster to (h,v) between pixel ticks; pipeline contents are left in flight.
  task automatic jump(input int h, input int v);
    while (((clk_cnt + 1) % PD) == 0) step();
    dut.u_timing.r_hc = 10'(h);
    dut.u_timing.r_vc = 10'(v);
    m_t = v * H_TOTAL + h;
  endtask

  task automatic fill_random();
    for (int c = 0; c < BW * BH; c++) board_state[c * 3 +: 3] = 3'($urandom_range(0, 7));
  endtask

  task automatic set_cell(input int h, input int v, input logic [2:0] code);
    board_state[(h * BH + v) * 3 +: 3] = code;
  endtask

  task automatic pass_snapshot();
    jump(795, 479);
    repeat (20) step();
  endtask

  task automatic test_reset();
    hard_reset = 1'b1;
    fill_random();
    repeat (3) @(negedge clk);
    n_total++;
    if (w_obs !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_outputs got %h want %h", w_obs, {12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
    else n_pass++;
    release_reset();
  endtask

  task automatic test_line_timing();
    int fall1, fall2, rise;
    logic prev_hs;
    fall1 = -1; fall2 = -1; rise = -1; prev_hs = 1'b1;
    repeat (3000) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL line_timing pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (prev_hs && !vga_hs) begin
        if (fall1 < 0) fall1 = clk_cnt;
        else if (fall2 < 0) fall2 = clk_cnt;
      end
      if (!prev_hs && vga_hs && rise < 0) rise = clk_cnt;
      prev_hs = vga_hs;
    end
    n_total++;
    if (fall1 != (656 + 2) * PD) $display("FAIL hs_first_fall got %0d want %0d", fall1, (656 + 2) * PD);
    else n_pass++;
    n_total++;
    if (rise - fall1 != 96 * PD) $display("FAIL hs_width got %0d want %0d", rise - fall1, 96 * PD);
    else n_pass++;
    n_total++;
    if (fall2 - fall1 != H_TOTAL * PD) $display("FAIL line_period got %0d want %0d", fall2 - fall1, H_TOTAL * PD);
    else n_pass++;
  endtask

  task automatic test_vsync();
    int low;
    low = 0;
    jump(780, 489);
    repeat (3400) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL vsync pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (!vga_vs) low++;
    end
    n_total++;
    if (low != 2 * H_TOTAL * PD) $display("FAIL vs_width got %0d want %0d", low, 2 * H_TOTAL * PD);
    else n_pass++;
    // Frame wrap 524 -> 0 back into the visible area.
    jump(790, 524);
    repeat (60) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL frame_wrap pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    int ticks;
    ticks = 0;
    fill_random();
    set_cell(0, 0, 3'd7);
    set_cell(1, 0, 3'd0);
    jump(780, 479);
    repeat (60) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL snapshot pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (frame_tick) ticks++;
    end
    n_total++;
    if (ticks != 1) $display("FAIL frame_tick_width got %0d want 1", ticks);
    else n_pass++;
    fill_random();
    jump(790, 524);
    repeat (300) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL dot_cell pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (exp_out.vc == 0 && exp_out.hc >= 0 && exp_out.hc <= 16) begin
        n_total++;
        if ({vga_r, vga_g, vga_b} !== ((exp_out.hc < 16) ? 12'hFF0 : 12'h000))
          $display("FAIL dot_rgb hc=%0d got %h want %h", exp_out.hc, {vga_r, vga_g, vga_b},
                   (exp_out.hc < 16) ? 12'hFF0 : 12'h000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_over();
    fill_random();
    set_cell(39, 29, 3'd1);
    is_over = 1'b0;
    pass_snapshot();
    for (int pass = 0; pass < 3; pass++) begin
      jump(600, 470 + pass);
      repeat (100) begin
        if (pass == 1) is_over = 1'b1;
        if (pass == 2) is_over = 1'($urandom_range(0, 1));
        step();
        n_total++;
        if (w_obs !== exp_vec())
          $display("FAIL over pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
        else n_pass++;
        if (pass < 2 && exp_out.vc == 470 + pass && exp_out.hc >= 624 && exp_out.hc <= 639) begin
          n_total++;
          if ({vga_r, vga_g, vga_b} !== ((pass == 1) ? 12'hF00 : 12'h0F0))
            $display("FAIL over_rgb hc=%0d got %h want %h", exp_out.hc, {vga_r, vga_g, vga_b},
                     (pass == 1) ? 12'hF00 : 12'h0F0);
          else n_pass++;
        end
      end
    end
    is_over = 1'b0;
  endtask

  task automatic test_midframe();
    int ticks;
    ticks = 0;
    fill_random();
    set_cell(0, 12, 3'd7);
    set_cell(0, 0, 3'd1);
    pass_snapshot();
    jump(0, 200);
    fill_random();
    set_cell(0, 12, 3'd1);
    set_cell(0, 0, 3'd7);
    repeat (200) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL midframe_old pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (exp_out.vc == 200 && exp_out.hc == 8) begin
        n_total++;
        if ({vga_r, vga_g, vga_b} !== 12'hFF0)
          $display("FAIL midframe_hold got %h want %h", {vga_r, vga_g, vga_b}, 12'hFF0);
        else n_pass++;
      end
    end
    jump(780, 479);
    repeat (60) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL midframe_snap pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (frame_tick) ticks++;
    end
    n_total++;
    if (ticks != 1) $display("FAIL midframe_tick_width got %0d want 1", ticks);
    else n_pass++;
    jump(790, 524);
    repeat (200) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL midframe_new pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (exp_out.vc == 0 && exp_out.hc == 8) begin
        n_total++;
        if ({vga_r, vga_g, vga_b} !== 12'hFF0)
          $display("FAIL midframe_update got %h want %h", {vga_r, vga_g, vga_b}, 12'hFF0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_start_screen();
    int yellow;
    yellow = 0;
    board_state = '1;
    pass_snapshot();
    is_start_screen = 1'b1;
    is_over = 1'($urandom_range(0, 1));
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0: jump(620, 0);
        1: jump(0, 200);
        2: jump(600, 470);
        default: jump(0, 100);
      endcase
      repeat (420) begin
        if (seg == 3) begin
          is_start_screen = 1'($urandom_range(0, 1));
          is_over = 1'b1;
        end
        step();
        n_total++;
        if (w_obs !== exp_vec())
          $display("FAIL start_screen pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
        else n_pass++;
        if (seg < 3 && {vga_r, vga_g, vga_b} == 12'hFF0) yellow++;
      end
    end
    n_total++;
    if (yellow != 0) $display("FAIL start_no_dot got %0d want 0", yellow);
    else n_pass++;
    is_start_screen = 1'b0;
    is_over = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int fall;
    logic prev_hs;
    board_state = '1;
    pass_snapshot();
    jump(296, 100);
    repeat (8) step();
    #2;
    hard_reset = 1'b1;
    #1;
    n_total++;
    if (w_obs !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset got %h want %h", w_obs, {12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
    else n_pass++;
    @(negedge clk);
    release_reset();
    fall = -1;
    prev_hs = 1'b1;
    repeat (1400) begin
      step();
      n_total++;
      if (w_obs !== exp_vec())
        $display("FAIL post_reset pix(%0d,%0d) got %h want %h", exp_out.hc, exp_out.vc, w_obs, exp_vec());
      else n_pass++;
      if (prev_hs && !vga_hs && fall < 0) fall = clk_cnt;
      prev_hs = vga_hs;
    end
    n_total++;
    if (fall != (656 + 2) * PD) $display("FAIL restart_hs_fall got %0d want %0d", fall, (656 + 2) * PD);
    else n_pass++;
  endtask

  initial begin
    hard_reset      = 1'b1;
    is_start_screen = 1'b0;
    is_over         = 1'b0;
    board_state     = '0;
    clk_cnt         = 0;
    m_t             = 0;
    m_shadow        = '0;
    exp_out         = rst_pix();
    exp_tick        = 1'b0;
    test_reset();
    test_line_timing();
    test_vsync();
    test_snapshot();
    test_over();
    test_midframe();
    test_start_screen();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/board_vga_renderer.md
Name: board_vga_renderer

Overview:
- Consumer end of the game engine's board_state bus. Drives a 640x480@60 VGA raster and reads the flattened 3-bit-per-cell board to colour each 16x16-pixel cell.
- Snapshots the board once per frame at the start of vertical blank, so a game tick in mid-frame cannot tear the image.
- Sits between main_game and the VGA DAC pins. Produces syncs, RGB, blank and a frame tick.

Parameters:
- BOARD_WIDTH, 40, cells horizontally (shared header).
- BOARD_HEIGHT, 30, cells vertically (shared header).
- CELL_PX, 16, pixels per cell edge (power of two).
- PIX_DIV, 2, clk cycles per pixel (pixel enable divider).

Ports:
- clk  in  1  system clock.
- hard_reset  in  1  active-high asynchronous reset.
- board_state  in  BOARD_WIDTH*BOARD_HEIGHT*3  cell (h,v) sits at bits [(h*BOARD_HEIGHT+v)*3 +: 3]. Codes: 0 empty, 1-4 snake, 7 dot, 5/6 unused.
- is_start_screen  in  1  start-screen overlay select.
- is_over  in  1  game-over colouring select.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- vga_hs, vga_vs  out  1 each  syncs, active-low.
- vga_blank_n  out  1  high during the visible area.
- frame_tick  out  1  one-clk pulse when the snapshot is taken.

Behaviour:
- Reset (async, hard_reset=1):
  - Counters and divider go to 0. Snapshot is cleared to all 0.
  - Outputs: vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_tick=0.
- Pixel enable: pix_en is 1 for one clk every PIX_DIV clks. The first pix_en is PIX_DIV clks after reset deasserts. All raster state advances only on pix_en.
- Horizontal counter hc, 0..799:
  - 0-639 visible; 640-655 front porch; 656-751 sync (hs=0); 752-799 back porch.
  - Wraps 799->0 and then increments vc.
- Vertical counter vc, 0..524:
  - 0-479 visible; 480-489 front porch; 490-491 sync (vs=0); 492-524 back porch.
  - Wraps 524->0.
- Snapshot:
  - Taken on the pix_en where hc==0 and vc==480. The whole board_state is copied into the shadow register.
  - frame_tick pulses high on that same clk.
  - The shadow is held unchanged for the entire next visible frame.
- Pipeline, 2 pixel stages:
  - S1 registers cell_h = hc/CELL_PX, cell_v = vc/CELL_PX and visible = (hc<640 && vc<480).
  - S2 looks up the shadow cell, maps it to a colour and registers RGB.
  - hs, vs and blank_n are delayed by 2 pix_en so they stay aligned with RGB. Total latency is 2 pixel ticks, fixed.
  - Cell indices are formed only when visible. Out-of-range indices are never used to address the shadow.
- Colour map (RGB 4-bit each), when visible:
  - Code 0: 000.
  - Codes 1-4: 0F0, or F00 if is_over.
  - Code 7: FF0.
  - Codes 5/6: 000.
- Start screen (is_start_screen=1): ignore the shadow.
  - Outer ring of cells (cell_h 0 or 39, cell_v 0 or 29) is 0F0.
  - Interior is 000.
- Overlay selects: is_start_screen and is_over are sampled in S1 each pixel, with no synchronisation, since they come from the same clock domain. is_start_screen takes priority over is_over.
- Blanking: when not visible, RGB=000 and blank_n=0.
- Reset mid-frame: everything returns to reset values at once. The raster restarts at hc=vc=0. The first snapshot occurs at the next vc=480.

Decomposition:
- Shared header game_vga_param.h holds:
  - board constants;
  - H/V timing constants (visible, front porch, sync, back porch);
  - cell codes CELL_EMPTY=0, CELL_UP..CELL_RIGHT=1..4, CELL_DOT=7;
  - colour constants.
- One sub-module, vga_timing_gen:
  - contains the divider and hc/vc counters;
  - outputs pix_en, hc, vc, raw hs/vs/visible.
- The renderer owns the snapshot, pipeline and colour map.

Test Plan:
- Reset then PIX_DIV=2 -> first hs fall at pixel 656. hs low for exactly 96 pixels (192 clks). Line period 1600 clks. Frame period 525 lines. vs low on lines 490-491.
- board_state with cell (0,0)=7, is_over=0 -> pixels hc 0-15, vc 0-15 read FF0 two pixel ticks after the matching hc. Pixel hc=16 reads 000. blank_n is aligned with RGB.
- Cell (39,29)=1, then is_over=1 -> pixels hc 624-639, vc 464-479 change from 0F0 to F00.
- Change board_state in mid-frame (vc=200) -> the rest of that frame shows the old board. The new board appears on the frame after frame_tick at vc=480. frame_tick is exactly one clk wide.
- is_start_screen=1 with board full of 7 -> ring cells 0F0, interior 000, no FF0 anywhere.
- Assert hard_reset at hc=300, vc=100 -> immediately hs=vs=1, RGB=0, blank_n=0. After release, counters restart at 0 and the shadow reads all 0 until the first snapshot.
